// File: rtl/pkg_config.sv
// Shared configuration for the ALU arbiter slice: data width, ALU opcodes
// and the arbiter FSM state type.
// Build option: define ALU_ARB_RR_EN for round-robin arbitration
// (default build is fixed priority, requester 0 first).
package pkg_config;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned OP_WIDTH   = 6;

  localparam logic [OP_WIDTH-1:0] OP_ALU_ADD  = 6'd0;
  localparam logic [OP_WIDTH-1:0] OP_ALU_SUB  = 6'd1;
  localparam logic [OP_WIDTH-1:0] OP_ALU_AND  = 6'd2;
  localparam logic [OP_WIDTH-1:0] OP_ALU_OR   = 6'd3;
  localparam logic [OP_WIDTH-1:0] OP_ALU_XOR  = 6'd4;
  localparam logic [OP_WIDTH-1:0] OP_ALU_SLL  = 6'd5;
  localparam logic [OP_WIDTH-1:0] OP_ALU_SRL  = 6'd6;
  localparam logic [OP_WIDTH-1:0] OP_ALU_SRA  = 6'd7;
  localparam logic [OP_WIDTH-1:0] OP_ALU_SLT  = 6'd8;
  localparam logic [OP_WIDTH-1:0] OP_ALU_SLTU = 6'd9;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_e;

endpackage

// File: rtl/alu_unit.sv
// Combinational ALU shared by all arbiter requesters.
// Shift amount is b[4:0]; add/sub wrap around; unknown opcodes give zero.
module alu_unit
  import pkg_config::*;
#(
  parameter int unsigned DATA_WIDTH = pkg_config::DATA_WIDTH
) (
  input  logic [OP_WIDTH-1:0]   op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] c_o
);

  logic [4:0] shamt;
  assign shamt = b_i[4:0];

  // Opcode decode and result select
  always_comb begin
    c_o = '0;
    case (op_i)
      OP_ALU_ADD:  c_o = a_i + b_i;
      OP_ALU_SUB:  c_o = a_i - b_i;
      OP_ALU_AND:  c_o = a_i & b_i;
      OP_ALU_OR:   c_o = a_i | b_i;
      OP_ALU_XOR:  c_o = a_i ^ b_i;
      OP_ALU_SLL:  c_o = a_i << shamt;
      OP_ALU_SRL:  c_o = a_i >> shamt;
      OP_ALU_SRA:  c_o = DATA_WIDTH'($signed(a_i) >>> shamt);
      OP_ALU_SLT:  c_o = DATA_WIDTH'($signed(a_i) < $signed(b_i));
      OP_ALU_SLTU: c_o = DATA_WIDTH'(a_i < b_i);
      default:     c_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end to a single ALU with a one-entry result register.
// Build option: ALU_ARB_RR_EN selects round-robin arbitration; otherwise
// requester 0 has fixed priority and no pointer register exists.
module alu_arbiter
  import pkg_config::*;
#(
  parameter int unsigned DATA_WIDTH = pkg_config::DATA_WIDTH,
  parameter int unsigned NUM_REQ    = 2
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NUM_REQ-1:0]                 req_valid_i,
  output logic [NUM_REQ-1:0]                 req_ready_o,
  input  logic [NUM_REQ-1:0][OP_WIDTH-1:0]   req_op_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_a_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_b_i,
  output logic                               rsp_valid_o,
  input  logic                               rsp_ready_i,
  output logic                               rsp_id_o,
  output logic [DATA_WIDTH-1:0]              rsp_data_o
);

  arb_state_e            state_q;
  arb_state_e            state_d;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic                  rsp_id_q;
  logic [NUM_REQ-1:0]    grant;
  logic                  can_accept;
  logic                  fire;
  logic                  sel;
  logic [DATA_WIDTH-1:0] alu_c;

`ifdef ALU_ARB_RR_EN
  // Index of the requester granted most recently; reset to 1 so 0 wins first.
  logic                  last_q;
`endif

  // Grant, handshake and next-state decode
  always_comb begin
    grant       = '0;
    can_accept  = 1'b0;
    req_ready_o = '0;
    fire        = 1'b0;
    sel         = 1'b0;
    state_d     = state_q;

`ifdef ALU_ARB_RR_EN
    if (&req_valid_i) begin
      grant = last_q ? 2'b01 : 2'b10;
    end else begin
      grant = req_valid_i;
    end
`else
    grant[0] = req_valid_i[0];
    grant[1] = req_valid_i[1] & ~req_valid_i[0];
`endif

    sel        = grant[1];
    can_accept = (state_q == ARB_IDLE) || ((state_q == ARB_HOLD) && rsp_ready_i);
    if (!rst_i) begin
      req_ready_o = grant & {NUM_REQ{can_accept}};
    end
    fire = |(req_valid_i & req_ready_o);

    case (state_q)
      ARB_IDLE: if (fire) state_d = ARB_HOLD;
      ARB_HOLD: begin
        if (fire) begin
          state_d = ARB_HOLD;
        end else if (rsp_ready_i) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Shared ALU fed by the granted requester
  alu_unit #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu (
    .op_i(req_op_i[sel]),
    .a_i (req_a_i[sel]),
    .b_i (req_b_i[sel]),
    .c_o (alu_c)
  );

  // State, result and pointer registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ARB_IDLE;
      rsp_data_q <= '0;
      rsp_id_q   <= 1'b0;
`ifdef ALU_ARB_RR_EN
      last_q     <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      if (fire) begin
        rsp_data_q <= alu_c;
        rsp_id_q   <= sel;
`ifdef ALU_ARB_RR_EN
        last_q     <= sel;
`endif
      end
    end
  end

  assign rsp_valid_o = (state_q == ARB_HOLD);
  assign rsp_data_o  = rsp_data_q;
  assign rsp_id_o    = rsp_id_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a transaction-level reference model.
// Honours ALU_ARB_RR_EN the same way as the design.
module tb_alu_arbiter;
  import pkg_config::*;

`ifdef ALU_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       req_valid = '0;
  logic [1:0]       req_ready;
  logic [1:0][5:0]  req_op = '0;
  logic [1:0][31:0] req_a = '0;
  logic [1:0][31:0] req_b = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b1;
  logic             rsp_id;
  logic [31:0]      rsp_data;

  alu_arbiter #(
    .DATA_WIDTH(32),
    .NUM_REQ   (2)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_op_i   (req_op),
    .req_a_i    (req_a),
    .req_b_i    (req_b),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_id_o   (rsp_id),
    .rsp_data_o (rsp_data)
  );

  always #5 clk = ~clk;

  // Reference ALU written from the opcode definitions
  function automatic logic [31:0] ref_alu(logic [5:0] op, logic [31:0] a, logic [31:0] b);
    int unsigned sh;
    sh = 32'(b) % 32;
    case (op)
      OP_ALU_ADD:  return a + b;
      OP_ALU_SUB:  return a - b;
      OP_ALU_AND:  return a & b;
      OP_ALU_OR:   return a | b;
      OP_ALU_XOR:  return a ^ b;
      OP_ALU_SLL:  return a << sh;
      OP_ALU_SRL:  return a >> sh;
      OP_ALU_SRA:  return $signed(a) >>> sh;
      OP_ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      default:     return 32'd0;
    endcase
  endfunction

  // Which requester may hand over a request this cycle
  function automatic logic [1:0] ref_ready(logic r, logic hold, logic rr, logic [1:0] v, logic last);
    int w;
    if (r || (hold && !rr) || (v == 2'b00)) return 2'b00;
    if (v == 2'b11) w = (RR_EN && !last) ? 1 : 0;
    else            w = v[1] ? 1 : 0;
    return 2'(1 << w);
  endfunction

  logic        m_hold  = 1'b0;
  logic [31:0] m_data  = '0;
  logic        m_id    = 1'b0;
  logic        m_last  = 1'b1;
  logic [1:0]  m_fired = '0;
  logic [1:0]  m_rdy;

  assign m_rdy = ref_ready(rst, m_hold, rsp_ready, req_valid, m_last);

  // Model update at each clock edge
  always @(posedge clk) begin
    if (rst) begin
      m_hold  <= 1'b0;
      m_data  <= '0;
      m_id    <= 1'b0;
      m_last  <= 1'b1;
      m_fired <= '0;
    end else begin
      m_fired <= m_rdy & req_valid;
      if (|(m_rdy & req_valid)) begin
        m_hold <= 1'b1;
        m_id   <= m_rdy[1];
        m_last <= m_rdy[1];
        m_data <= ref_alu(req_op[m_rdy[1]], req_a[m_rdy[1]], req_b[m_rdy[1]]);
      end else if (rsp_ready) begin
        m_hold <= 1'b0;
      end
    end
  end

  // Hand-computed expectations pinned for the next falling edge
  logic        pin_en = 1'b0;
  logic        pin_valid = 1'b0;
  logic        pin_id = 1'b0;
  logic [31:0] pin_data = '0;
  logic        pin_rdy_en = 1'b0;
  logic [1:0]  pin_rdy = '0;

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: model every cycle, pinned literals when present
  initial begin
    forever begin
      @(negedge clk);
      chk("req_ready", 32'(req_ready), 32'(m_rdy));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_hold));
      if (m_hold) begin
        chk("rsp_data", rsp_data, m_data);
        chk("rsp_id", 32'(rsp_id), 32'(m_id));
      end
      if (pin_en) begin
        chk("lit_valid", 32'(rsp_valid), 32'(pin_valid));
        chk("lit_id", 32'(rsp_id), 32'(pin_id));
        chk("lit_data", rsp_data, pin_data);
      end
      if (pin_rdy_en) chk("lit_ready", 32'(req_ready), 32'(pin_rdy));
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
    pin_en     = 1'b0;
    pin_rdy_en = 1'b0;
  endtask

  task automatic set_pin(logic v, logic id, logic [31:0] d);
    pin_en    = 1'b1;
    pin_valid = v;
    pin_id    = id;
    pin_data  = d;
  endtask

  task automatic set_pin_rdy(logic [1:0] r);
    pin_rdy_en = 1'b1;
    pin_rdy    = r;
  endtask

  task automatic load(int k, logic [5:0] op, logic [31:0] a, logic [31:0] b);
    req_op[k]    = op;
    req_a[k]     = a;
    req_b[k]     = b;
    req_valid[k] = 1'b1;
  endtask

  // Wait (bounded) for requester k to fire, then drop its valid
  task automatic wait_fire(int k);
    bit done;
    done = 1'b0;
    for (int n = 0; n < 20 && !done; n++) begin
      cycle();
      if (m_fired[k]) done = 1'b1;
    end
    if (!done) begin
      $display("FAIL fire_timeout: requester %0d got no grant within 20 cycles", k);
      $fatal(1, "timeout");
    end
    req_valid[k] = 1'b0;
  endtask

  // Requester k must fire at the very next edge
  task automatic step_fire(int k);
    cycle();
    if (!m_fired[k]) begin
      $display("FAIL step_fire: requester %0d not accepted at expected edge", k);
      $fatal(1, "no fire");
    end
    req_valid[k] = 1'b0;
  endtask

  logic [5:0]  t_op [9] = '{OP_ALU_AND, OP_ALU_XOR, OP_ALU_SLL, OP_ALU_SRL, OP_ALU_SLT,
                            OP_ALU_ADD, OP_ALU_SUB, OP_ALU_SRA, OP_ALU_SLTU};
  logic [31:0] t_a  [9] = '{32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0000_0001, 32'h8000_0000,
                            32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000,
                            32'hFFFF_FFFF};
  logic [31:0] t_b  [9] = '{32'h0FF0_0FF0, 32'h0F0F_0F0F, 32'h0000_003F, 32'h0000_0004,
                            32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0024,
                            32'h0000_0001};
  logic [31:0] t_c  [9] = '{32'h00F0_00F0, 32'hF0F0_0F0F, 32'h8000_0000, 32'h0800_0000,
                            32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 32'hF800_0000,
                            32'h0000_0000};

  // Directed stimulus
  initial begin
    rst = 1'b1;
    repeat (3) cycle();
    rst = 1'b0;
    set_pin(1'b0, 1'b0, 32'h0);
    set_pin_rdy(2'b00);
    cycle();

    // Both requesters valid right after reset: 0 then 1, back to back
    rsp_ready = 1'b1;
    load(0, OP_ALU_SUB, 32'd5, 32'd3);
    load(1, OP_ALU_OR, 32'h0000_0101, 32'h0001_0001);
    set_pin_rdy(2'b01);
    step_fire(0);
    set_pin(1'b1, 1'b0, 32'h0000_0002);
    set_pin_rdy(2'b10);
    step_fire(1);
    set_pin(1'b1, 1'b1, 32'h0001_0101);
    cycle();

    // Single add
    load(0, OP_ALU_ADD, 32'd1, 32'd1);
    wait_fire(0);
    set_pin(1'b1, 1'b0, 32'h0000_0002);
    cycle();

    // req0 held valid continuously with req1 also valid
    load(1, OP_ALU_XOR, 32'h1234_5678, 32'hFFFF_0000);
    for (int i = 1; i <= 4; i++) begin
      load(0, OP_ALU_ADD, 32'(i), 32'(i));
`ifndef ALU_ARB_RR_EN
      set_pin_rdy(2'b01);
`endif
      cycle();
`ifndef ALU_ARB_RR_EN
      set_pin(1'b1, 1'b0, 32'(2 * i));
`endif
    end
    req_valid[0] = 1'b0;
    wait_fire(1);
    set_pin(1'b1, 1'b1, 32'hEDCB_5678);
    cycle();

    // Backpressure on an SRA result, then back-to-back SLTU from req1
    rsp_ready = 1'b0;
    cycle();
    load(0, OP_ALU_SRA, 32'hFFFF_F000, 32'd4);
    wait_fire(0);
    load(1, OP_ALU_SLTU, 32'd10, 32'hFFFF_FFF0);
    for (int i = 0; i < 3; i++) begin
      set_pin(1'b1, 1'b0, 32'hFFFF_FF00);
      set_pin_rdy(2'b00);
      cycle();
    end
    rsp_ready = 1'b1;
    set_pin(1'b1, 1'b0, 32'hFFFF_FF00);
    set_pin_rdy(2'b10);
    step_fire(1);
    set_pin(1'b1, 1'b1, 32'h0000_0001);
    cycle();

    // Reset while holding a result
    rsp_ready = 1'b0;
    load(1, OP_ALU_SUB, 32'd0, 32'd1);
    wait_fire(1);
    load(0, OP_ALU_AND, 32'hFF00_FF00, 32'h0FF0_0FF0);
    load(1, OP_ALU_XOR, 32'hAAAA_AAAA, 32'h5555_5555);
    set_pin(1'b1, 1'b1, 32'hFFFF_FFFF);
    rst = 1'b1;
    set_pin_rdy(2'b00);
    cycle();
    rst = 1'b0;
    set_pin(1'b0, 1'b0, 32'h0);
    set_pin_rdy(2'b01);
    step_fire(0);
    set_pin(1'b1, 1'b0, 32'h0F00_0F00);
    rsp_ready = 1'b1;
    step_fire(1);
    set_pin(1'b1, 1'b1, 32'hFFFF_FFFF);
    cycle();

    // Opcode table, alternating requesters
    for (int i = 0; i < 9; i++) begin
      load(i % 2, t_op[i], t_a[i], t_b[i]);
      wait_fire(i % 2);
      set_pin(1'b1, 1'((i % 2)), t_c[i]);
    end
    repeat (3) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL take parameter DATA_WIDTH, default pkg_config::DATA_WIDTH (32), operand/result width.
REQ-002 The block SHALL take parameter NUM_REQ, default 2 (fixed), number of requesters.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 The block SHALL have port clk_i, input, 1, sole clock.
REQ-005 The block SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-006 The block SHALL have port req_valid_i, input, NUM_REQ, per-requester request valid.
REQ-007 The block SHALL have port req_ready_o, output, NUM_REQ, per-requester request accepted.
REQ-008 The block SHALL have port req_op_i, input, NUM_REQ x 6, per-requester ALU opcode (OP_ALU_* encoding).
REQ-009 The block SHALL have port req_a_i, input, NUM_REQ x DATA_WIDTH, per-requester operand A.
REQ-010 The block SHALL have port req_b_i, input, NUM_REQ x DATA_WIDTH, per-requester operand B.
REQ-011 The block SHALL have port rsp_valid_o, output, 1, result valid.
REQ-012 The block SHALL have port rsp_ready_i, input, 1, result consumer ready.
REQ-013 The block SHALL have port rsp_id_o, output, 1, index of the requester owning the result.
REQ-014 The block SHALL have port rsp_data_o, output, DATA_WIDTH, registered ALU result.

Function
REQ-015 The block SHALL run a two-state FSM: IDLE (no result held) and HOLD (result held, rsp_valid_o=1).
REQ-016 Each cycle it SHALL compute a combinational one-hot grant among asserted req_valid_i bits; no valid requests means no grant.
REQ-017 can_accept SHALL equal (state==IDLE) or (state==HOLD and rsp_ready_i); req_ready_o[k] SHALL equal grant[k] and can_accept.
REQ-018 A request SHALL fire when req_valid_i[k] and req_ready_o[k] are both high; at most one request fires per cycle.
REQ-019 On fire, the granted op/a/b SHALL drive the single shared alu_unit combinationally, and c_o, the index and the next state SHALL be registered at that clock edge.
REQ-020 Latency SHALL be 1 cycle: a request firing in cycle N gives rsp_valid_o=1 with its result and id in cycle N+1.
REQ-021 Transition IDLE->HOLD on fire; HOLD->IDLE on rsp_ready_i with no fire; HOLD->HOLD on simultaneous rsp_ready_i and fire (back-to-back, one result per cycle).
REQ-022 In HOLD with rsp_ready_i=0, rsp_data_o/rsp_id_o SHALL stay stable and req_ready_o SHALL be all zero.
REQ-023 Requesters SHALL hold valid and payload stable until fire; the block SHALL NOT drop a valid unfired request.
REQ-024 Results SHALL follow alu_unit semantics exactly (width DATA_WIDTH, shift amount b[4:0], wrap-around add/sub).

Reset
REQ-025 While rst_i is high at a clock edge, the block SHALL set state=IDLE, rsp_valid_o=0, rsp_data_o=0, rsp_id_o=0 and round-robin pointer=1, and SHALL hold req_ready_o at 0.
REQ-026 Reset asserted in HOLD SHALL discard the held result without a handshake.

Configuration
REQ-027 With ALU_ARB_RR_EN defined, arbitration SHALL be round-robin: when both requesters are valid, the one not granted last wins; the pointer updates only on fire; after reset requester 0 wins first.
REQ-028 Without ALU_ARB_RR_EN, arbitration SHALL be fixed priority (requester 0 always wins) and the pointer register SHALL NOT exist.

Structure
REQ-029 pkg_config SHALL hold DATA_WIDTH, the OP_ALU_* opcode constants and the arbiter FSM state enum typedef.
REQ-030 The block SHALL instantiate exactly one alu_unit sub-module and no other sub-modules.

Verification
REQ-031 Single add: req0 OP_ALU_ADD a=1 b=1 -> 1 cycle later rsp_valid_o=1, id=0, data=0000_0002.
REQ-032 Both valid with RR enabled: req0 OP_ALU_SUB 5-3, req1 OP_ALU_OR 0000_0101|0001_0001, rsp_ready_i=1 -> id 0 data 0000_0002, then id 1 data 0001_0101 on consecutive cycles.
REQ-033 Fixed priority: req0 held valid continuously and req1 valid -> req1 never granted while req0 valid.
REQ-034 Backpressure: rsp_ready_i=0 for 3 cycles after OP_ALU_SRA a=FFFF_F000 b=4 -> data FFFF_FF00 held stable and req_ready_o=0, then released on rsp_ready_i=1.
REQ-035 Back-to-back: rsp_ready_i=1 and req1 OP_ALU_SLTU a=10 b=FFFF_FFF0 in HOLD -> next cycle data 0000_0001, id=1, no bubble.
REQ-036 Reset mid-HOLD: assert rst_i for one cycle -> rsp_valid_o=0 and rsp_data_o=0 on the next cycle, with req0 granted first afterwards.
